// File: rtl/serial_negator_lanes.sv
// serial_negator_lanes
//   LSB-first serial two's-complement unit handling LANES bits per beat and
//   WORD_LEN-bit words. Each word is either passed through or negated; the
//   mode is sampled on the first beat of the word and held for the rest of it.
//   Negation uses the classic "seen-a-one" rule: bits are copied up to and
//   including the first 1, and every bit after it is inverted.
//   Valid/ready on both sides; the output is a single register stage without
//   a skid buffer, so latency is one cycle from accept to out_valid.
//
// Optional feature macro: SAT_DETECT_EN
//   When defined, out_ovf flags the last beat of a negated word whose value is
//   the most-negative pattern 100...0 (its negation wraps back to itself).
//   When undefined, out_ovf is tied to 0.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort: drops the current word and the output beat
//   mode       0 = pass, 1 = negate (sampled on beat 0 of each word)
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_data    input bits, bit 0 least significant
//   out_valid  output beat valid
//   out_ready  consumer ready
//   out_data   result bits
//   out_last   final beat of a word
//   out_ovf    most-negative negation flag (SAT_DETECT_EN only)
module serial_negator_lanes #(
  parameter int LANES    = 1,
  parameter int WORD_LEN = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic             out_last,
  output logic             out_ovf
);

  localparam int BEATS = WORD_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic {S_NONE = 1'b0, S_SEEN = 1'b1} state_t;

  // Bit-serial negation across the lanes of one beat; carry starts at the
  // word-level "seen" flag and ripples up as soon as any lower bit is 1.
  function automatic logic [LANES-1:0] negate_beat(
    input logic [LANES-1:0] d,
    input logic             seen_in,
    input logic             neg
  );
    logic [LANES-1:0] r;
    logic             c;
    r = '0;
    c = seen_in;
    for (int i = 0; i < LANES; i++) begin
      r[i] = d[i] ^ (neg & c);
      c    = c | d[i];
    end
    return r;
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] beat_cnt, cnt_next;
  logic             mode_q, mode_next;
  logic             seen, first_beat, last_beat, eff_mode, accept;
  logic [LANES-1:0] result;
  logic             vld_p1, last_p1;
  logic [LANES-1:0] data_p1;

  assign in_ready   = !vld_p1 || out_ready;
  assign accept     = in_valid && in_ready && !clr;
  assign seen       = (state == S_SEEN);
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign eff_mode   = first_beat ? mode : mode_q;
  assign result     = negate_beat(in_data, seen, eff_mode);

  always_comb begin
    state_next = state;
    cnt_next   = beat_cnt;
    mode_next  = mode_q;
    if (clr) begin
      state_next = S_NONE;
      cnt_next   = '0;
    end else if (accept) begin
      if (first_beat) mode_next = mode;
      if (last_beat) begin
        state_next = S_NONE;
        cnt_next   = '0;
      end else begin
        state_next = (seen || (|in_data)) ? S_SEEN : S_NONE;
        cnt_next   = beat_cnt + CNT_W'(1);
      end
    end
  end

  // Stage p0 -> p1: word state update and output register load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_NONE;
      beat_cnt <= '0;
      mode_q   <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      data_p1  <= '0;
    end else begin
      state    <= state_next;
      beat_cnt <= cnt_next;
      mode_q   <= mode_next;
      if (clr) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1  <= 1'b1;
        data_p1 <= result;
        last_p1 <= last_beat;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

`ifdef SAT_DETECT_EN
  // Most-negative detection: the last beat must carry MSB=1 with every
  // lower bit of the whole word zero, and the word must be negated.
  function automatic logic ovf_flag(
    input logic [LANES-1:0] d,
    input logic             zeros_low,
    input logic             neg
  );
    logic [LANES-1:0] low_mask;
    low_mask = ~(LANES'(1) << (LANES - 1));
    return neg & d[LANES-1] & zeros_low & ~(|(d & low_mask));
  endfunction

  logic zeros_q, zeros_next, ovf_now, ovf_p1;

  assign ovf_now = last_beat & ovf_flag(in_data, zeros_q, eff_mode);

  always_comb begin
    zeros_next = zeros_q;
    if (clr) zeros_next = 1'b1;
    else if (accept) zeros_next = last_beat ? 1'b1 : (zeros_q & ~(|in_data));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zeros_q <= 1'b1;
      ovf_p1  <= 1'b0;
    end else begin
      zeros_q <= zeros_next;
      if (clr) ovf_p1 <= 1'b0;
      else if (accept) ovf_p1 <= ovf_now;
    end
  end

  assign out_ovf = ovf_p1;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;

endmodule

// File: doc/serial_negator_lanes.md
Name: serial_negator_lanes

Overview:
- Parametrised LSB-first serial two's-complement unit (Mealy "seen-a-one" FSM), generalised to LANES bits per clock and WORD_LEN-bit words.
- Runtime mode select: pass-through or negate.
- Valid/ready streaming on both sides, with a registered output stage.
- Sits between serial datapath producers and consumers in the serial arithmetic chain.

Parameters:
- LANES, 1, bits processed per accepted beat (1..16).
- WORD_LEN, 8, bits per word. Must be a multiple of LANES and at least 2*LANES.
- BEATS (localparam), WORD_LEN/LANES, beats per word.
- CNT_W (localparam), max(1, clog2(BEATS)), beat counter width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort: drops current word and output beat
- mode  in  1  0 = pass, 1 = negate; sampled on first beat of each word
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES  input bits; bit 0 is least significant of the beat
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer ready
- out_data  out  LANES  result bits
- out_last  out  1  marks final beat of a word
- out_ovf  out  1  overflow flag (SAT_DETECT_EN only; tie 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_last=0, out_ovf=0, beat_cnt=0, seen=0, mode_q=0. in_ready=1 after reset.
- in_ready = !out_valid || out_ready. This is a single pipeline register with no skid; full throughput when out_ready=1.
- Output register loads on an accepted beat, so latency is exactly 1 cycle from accept to out_valid.
- out_valid clears when out_ready=1 and no new beat is accepted.
- FSM per word has two states:
  - S_NONE: no 1 seen yet in the word.
  - S_SEEN: a 1 has been seen.
  - seen flag = (state == S_SEEN).
- Effective mode:
  - eff_mode = mode on beat 0.
  - eff_mode = mode_q on later beats.
  - mode_q latches mode on beat 0.
- Per-bit output with carry-in c0 = seen:
  - c[i] = seen | (|in_data[i-1:0]).
  - result[i] = in_data[i] ^ (eff_mode & c[i]).
  - In pass mode, result = in_data.
- Next state:
  - seen_next = seen | (|in_data).
  - On the last beat (beat_cnt == BEATS-1), seen_next=0 and beat_cnt=0, ready for the next word.
  - Otherwise beat_cnt increments on each accepted beat.
  - seen is updated in both modes.
- out_last is registered: 1 when the loaded beat had beat_cnt == BEATS-1.
- No state change when no beat is accepted, including when out_valid=1 && out_ready=0.
- clr=1 (priority over transfer): beat_cnt=0, seen=0, out_valid=0, out_last=0, out_ovf=0; any input beat in that cycle is discarded.
- Simultaneous drain and load (out_valid=1, out_ready=1, in_valid=1): the new beat replaces the old one in the same cycle.
- Reset mid-word: the partial word is lost; the next accepted beat is beat 0.

Optional Feature:
- SAT_DETECT_EN defined:
  - Tracks whether all non-MSB bits of the word were 0 (most-negative pattern 100...0).
  - On the last beat, out_ovf=1 iff eff_mode=1, MSB=1 and all lower bits=0; out_ovf=0 on all other beats.
  - Data output is unchanged (wraps to 100...0).
- SAT_DETECT_EN undefined: no tracking logic; out_ovf is tied to 0.

Test Plan:
- LANES=1, WORD_LEN=8, mode=1, word 0x05 LSB-first (1,0,1,0,0,0,0,0), out_ready=1 -> out bits 1,1,0,1,1,1,1,1 (0xFB), 1-cycle latency, out_last on 8th beat.
- LANES=4, WORD_LEN=8, mode=1, beats 0xC then 0x0 (word 0x0C) -> out beats 0x4 then 0xF (0xF4). Then back-to-back word 0x00 -> 0x0, 0x0, confirming seen is cleared at the word boundary.
- LANES=1, mode=1 on beat 0 then toggled to 0 mid-word, word 0x01 -> 0xFF (mode latched); next word 0x5A with mode=0 -> 0x5A.
- Backpressure: out_ready=0 for 3 cycles mid-word -> out_data/out_last held, in_ready=0, beat_cnt frozen; after release the completed word equals the unstalled result, with no beats lost or duplicated.
- SAT_DETECT_EN, LANES=1, mode=1, word 0x80 -> out 0x80, out_ovf=1 only on the last beat. Word 0x81 -> 0x7F, out_ovf=0.
- Abort/reset handling:
  - clr pulse after 3 beats of word 0x05 -> out_valid=0 next cycle; a fresh word 0x03 then yields 0xFD.
  - rst_n low mid-word -> all outputs 0 asynchronously, and the next word is processed from beat 0.
